// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host receiver: conditions the raw pins, deserializes 11-bit frames,
// publishes valid bytes and tracks the make code of the currently held key.
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic [7:0] ps2_key_held,
  output logic       frame_error
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

  logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic          filt_clk_r, fall_r;
  logic [FW-1:0] filt_cnt_r;
  state_t        state_r, state_s;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [TW-1:0] to_cnt_r;
  logic          timeout_s, frame_ok_s, frame_bad_s;
  logic          break_pending_r;

  // Two-flop synchronizers for both pins, preset to the idle-high level
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clock;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter; the falling-edge strobe is raised in the same cycle the filter flips
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_clk_r <= 1'b1;
      filt_cnt_r <= '0;
      fall_r     <= 1'b0;
    end else begin
      fall_r <= 1'b0;
      if (clk_sync_r == filt_clk_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FILT_LAST) begin
        filt_clk_r <= clk_sync_r;
        filt_cnt_r <= '0;
        fall_r     <= filt_clk_r;
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  assign timeout_s = (state_r != IDLE) && !fall_r && (to_cnt_r == TO_LAST);

  // Mid-frame watchdog, restarted by every filtered falling edge
  always_ff @(posedge clock) begin
    if (reset || (state_r == IDLE) || fall_r || timeout_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: advances only on filtered falling edges
  always_comb begin
    state_s = state_r;
    if (timeout_s) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (fall_r && !data_sync_r) state_s = DATA; else state_s = IDLE;
        DATA:    if (fall_r && (bit_cnt_r == 3'd7)) state_s = PARITY; else state_s = DATA;
        PARITY:  if (fall_r) state_s = STOP; else state_s = PARITY;
        STOP:    if (fall_r) state_s = IDLE; else state_s = STOP;
        default: state_s = IDLE;
      endcase
    end
  end

  // FSM outputs: frame verdict on the stop-bit edge, or a watchdog abort
  always_comb begin
    frame_ok_s  = 1'b0;
    frame_bad_s = 1'b0;
    if ((state_r == STOP) && fall_r) begin
      if (data_sync_r && odd_parity_ok(shift_r, parity_r)) begin
        frame_ok_s = 1'b1;
      end else begin
        frame_bad_s = 1'b1;
      end
    end else begin
      frame_bad_s = timeout_s;
    end
  end

  // Frame datapath: LSB-first shift register, bit counter, parity capture
  always_ff @(posedge clock) begin
    if (reset || timeout_s) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
    end else if (fall_r) begin
      case (state_r)
        IDLE:    bit_cnt_r <= 3'd0;
        DATA: begin
          shift_r   <= {data_sync_r, shift_r[7:1]};
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
        PARITY:  parity_r <= data_sync_r;
        default: bit_cnt_r <= bit_cnt_r;
      endcase
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Registered outputs and make/break tracking on valid bytes
  always_ff @(posedge clock) begin
    if (reset) begin
      ps2_key_pressed <= 1'b0;
      frame_error     <= 1'b0;
      ps2_out         <= 8'h00;
      ps2_key_held    <= 8'h00;
      break_pending_r <= 1'b0;
    end else begin
      ps2_key_pressed <= frame_ok_s;
      frame_error     <= frame_bad_s;
      if (frame_ok_s) begin
        ps2_out <= shift_r;
        if (shift_r == BREAK_CODE) begin
          break_pending_r <= 1'b1;
        end else if (shift_r == EXT_CODE) begin
          break_pending_r <= break_pending_r;
        end else if (break_pending_r) begin
          break_pending_r <= 1'b0;
          if (shift_r == ps2_key_held) ps2_key_held <= 8'h00;
        end else begin
          ps2_key_held <= shift_r;
        end
      end
    end
  end

endmodule
